// File: rtl/wbm_spi_ctrl_if.sv
// ---------------------------------------------------------------------------
// wbm_spi_ctrl_if
// Groups the byte-link handshakes and the Wishbone B4 pipelined master pins
// used by wbm_spi_ctrl.
//   rx_valid_i/rx_data_i   received byte strobe and data (into the sequencer)
//   tx_valid_o/tx_data_o   byte to transmit, held until tx_ready_i
//   tx_ready_i             transmit path accepts the byte
//   wbm_*                  single-beat Wishbone pipelined master signals
// modport master: the sequencer side.  modport slave: the far side
// (byte link and bus slave).
// ---------------------------------------------------------------------------
interface wbm_spi_ctrl_if;
    logic        rx_valid_i;
    logic [7:0]  rx_data_i;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        tx_ready_i;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [7:0]  wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_stall_i;
    logic        wbm_ack_i;

    modport master (
        input  rx_valid_i, rx_data_i, tx_ready_i,
        input  wbm_dat_i, wbm_stall_i, wbm_ack_i,
        output tx_valid_o, tx_data_o,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );

    modport slave (
        output rx_valid_i, rx_data_i, tx_ready_i,
        output wbm_dat_i, wbm_stall_i, wbm_ack_i,
        input  tx_valid_o, tx_data_o,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );
endinterface

// File: rtl/wbm_spi_ctrl.sv
// ---------------------------------------------------------------------------
// wbm_spi_ctrl
// Command sequencer between the SPI byte link and a Wishbone B4 pipelined
// master. Each received frame {CMD, ADR[, D3, D2, D1, D0]} runs one
// single-beat bus cycle; a status byte (0x00 ok, 0xEE timeout) is returned,
// followed by four read-data bytes (MSB first) for reads.
// Ports:
//   wbm_clk_i   clock for all logic
//   wbm_rst_i   synchronous active-high reset
//   bus         wbm_spi_ctrl_if.master: rx/tx byte handshakes + wbm_* pins
//   overrun_o   sticky flag: a byte arrived while busy and was dropped
// Parameter:
//   TIMEOUT     cycles to wait for ack after strobe acceptance (1..65535)
// ---------------------------------------------------------------------------
module wbm_spi_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  wbm_clk_i,
    input  logic                  wbm_rst_i,
    wbm_spi_ctrl_if.master        bus,
    output logic                  overrun_o
);

    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT);

    typedef enum logic [2:0] {
        S_CMD, S_ADR, S_WDATA, S_REQ, S_WAIT, S_RESP
    } state_t;

    state_t      state_q;
    logic        we_q;
    logic [3:0]  sel_q;
    logic [7:0]  adr_q;
    logic [31:0] dat_q;
    logic [1:0]  wcnt_q;
    logic        cyc_q;
    logic        stb_q;
    logic [15:0] tmo_q;
    logic [39:0] resp_q;    // {status, read data}; top byte is on tx_data_o
    logic [2:0]  rem_q;     // bytes still to send after the current one
    logic        tx_valid_q;
    logic        overrun_q;

    always_ff @(posedge wbm_clk_i) begin
        if (wbm_rst_i) begin
            state_q    <= S_CMD;
            we_q       <= 1'b0;
            sel_q      <= 4'h0;
            adr_q      <= 8'h00;
            dat_q      <= 32'h0;
            wcnt_q     <= 2'd0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            tmo_q      <= 16'd0;
            resp_q     <= 40'h0;
            rem_q      <= 3'd0;
            tx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            case (state_q)
                S_CMD: begin
                    if (bus.rx_valid_i) begin
                        we_q    <= bus.rx_data_i[7];
                        sel_q   <= bus.rx_data_i[3:0];
                        state_q <= S_ADR;
                    end
                end
                S_ADR: begin
                    if (bus.rx_valid_i) begin
                        adr_q  <= bus.rx_data_i;
                        wcnt_q <= 2'd0;
                        if (we_q) begin
                            state_q <= S_WDATA;
                        end else begin
                            cyc_q   <= 1'b1;
                            stb_q   <= 1'b1;
                            state_q <= S_REQ;
                        end
                    end
                end
                S_WDATA: begin
                    if (bus.rx_valid_i) begin
                        dat_q  <= {dat_q[23:0], bus.rx_data_i};
                        wcnt_q <= wcnt_q + 2'd1;
                        if (wcnt_q == 2'd3) begin
                            cyc_q   <= 1'b1;
                            stb_q   <= 1'b1;
                            state_q <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (bus.rx_valid_i) overrun_q <= 1'b1;
                    // Stalled cycles are not timed; only an acceptance moves on.
                    if (!bus.wbm_stall_i) begin
                        stb_q <= 1'b0;
                        tmo_q <= 16'd1;
                        if (bus.wbm_ack_i) begin
                            cyc_q      <= 1'b0;
                            resp_q     <= {8'h00, (we_q ? 32'h0 : bus.wbm_dat_i)};
                            rem_q      <= we_q ? 3'd0 : 3'd4;
                            tx_valid_q <= 1'b1;
                            state_q    <= S_RESP;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.rx_valid_i) overrun_q <= 1'b1;
                    // tmo_q counts cycles since acceptance; ack wins over timeout.
                    if (bus.wbm_ack_i) begin
                        cyc_q      <= 1'b0;
                        resp_q     <= {8'h00, (we_q ? 32'h0 : bus.wbm_dat_i)};
                        rem_q      <= we_q ? 3'd0 : 3'd4;
                        tx_valid_q <= 1'b1;
                        state_q    <= S_RESP;
                    end else if (tmo_q == TMO_LIMIT) begin
                        cyc_q      <= 1'b0;
                        resp_q     <= {8'hEE, 32'h0};
                        rem_q      <= we_q ? 3'd0 : 3'd4;
                        tx_valid_q <= 1'b1;
                        state_q    <= S_RESP;
                    end else begin
                        tmo_q <= tmo_q + 16'd1;
                    end
                end
                S_RESP: begin
                    // A byte arriving alongside the last handshake is still dropped.
                    if (bus.rx_valid_i) overrun_q <= 1'b1;
                    if (bus.tx_ready_i) begin
                        resp_q <= {resp_q[31:0], 8'h00};
                        if (rem_q == 3'd0) begin
                            tx_valid_q <= 1'b0;
                            state_q    <= S_CMD;
                        end else begin
                            rem_q <= rem_q - 3'd1;
                        end
                    end
                end
                default: state_q <= S_CMD;
            endcase
        end
    end

    assign bus.tx_valid_o = tx_valid_q;
    assign bus.tx_data_o  = resp_q[39:32];
    assign bus.wbm_cyc_o  = cyc_q;
    assign bus.wbm_stb_o  = stb_q;
    assign bus.wbm_we_o   = we_q;
    assign bus.wbm_sel_o  = sel_q;
    assign bus.wbm_adr_o  = adr_q;
    assign bus.wbm_dat_o  = dat_q;
    assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_wbm_spi_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wbm_spi_ctrl
// Scoreboard bench for wbm_spi_ctrl: expected tx bytes are queued when a
// frame is issued; a monitor pops and compares on every tx handshake.
// Bus-side expectations are checked by the bus slave model at acceptance.
// ---------------------------------------------------------------------------
module tb_wbm_spi_ctrl;

    localparam int TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst;
    logic overrun;

    wbm_spi_ctrl_if bus ();

    wbm_spi_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .wbm_clk_i (clk),
        .wbm_rst_i (rst),
        .bus       (bus),
        .overrun_o (overrun)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // tx scoreboard monitor: tx_ready_i only changes just after posedge,
    // so its negedge value is the one the DUT sees at the next edge.
    always @(negedge clk) begin
        if (!rst && bus.tx_valid_o && bus.tx_ready_i) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL tx_unexpected: got %0h, expected no byte", bus.tx_data_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("tx_byte", 64'(bus.tx_data_o), 64'(mon_e));
            end
        end
    end

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        bus.rx_valid_i = 1'b1;
        bus.rx_data_i  = b;
        @(posedge clk); #1;
        bus.rx_valid_i = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] adr, input logic [31:0] d);
        send(cmd);
        send(adr);
        if (cmd[7]) begin
            send(d[31:24]);
            send(d[23:16]);
            send(d[15:8]);
            send(d[7:0]);
        end
    endtask

    task automatic push5(input logic [7:0] st, input logic [31:0] d);
        exp_q.push_back(st);
        exp_q.push_back(d[31:24]);
        exp_q.push_back(d[23:16]);
        exp_q.push_back(d[15:8]);
        exp_q.push_back(d[7:0]);
    endtask

    task automatic wait_req(output int k);
        k = 0;
        @(negedge clk);
        while (!(bus.wbm_cyc_o && bus.wbm_stb_o) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("req_seen", 64'(k < 100), 64'(1));
    endtask

    // Bus slave: stall for 'stalls' cycles, then accept; ack_dly<0 means never ack.
    task automatic bus_xact(input int stalls, input int ack_dly, input logic [31:0] rdata,
                            input logic [7:0] e_adr, input logic [3:0] e_sel,
                            input logic e_we, input logic [31:0] e_dat);
        int k;
        wait_req(k);
        if (k >= 100) return;
        for (int i = 0; i < stalls; i++) begin
            bus.wbm_stall_i = 1'b1;
            check("stb_held", 64'(bus.wbm_stb_o), 64'(1));
            @(negedge clk);
        end
        bus.wbm_stall_i = 1'b0;
        check("stb_accept", 64'(bus.wbm_stb_o), 64'(1));
        check("adr", 64'(bus.wbm_adr_o), 64'(e_adr));
        check("sel", 64'(bus.wbm_sel_o), 64'(e_sel));
        check("we",  64'(bus.wbm_we_o),  64'(e_we));
        if (e_we) check("dat_o", 64'(bus.wbm_dat_o), 64'(e_dat));
        if (ack_dly == 0) begin
            bus.wbm_ack_i = 1'b1;
            bus.wbm_dat_i = rdata;
        end
        @(negedge clk);
        bus.wbm_ack_i = 1'b0;
        check("stb_dropped", 64'(bus.wbm_stb_o), 64'(0));
        if (ack_dly == 0) begin
            check("cyc_fast_ack", 64'(bus.wbm_cyc_o), 64'(0));
            check("tx_valid_after_ack", 64'(bus.tx_valid_o), 64'(1));
        end else if (ack_dly > 0) begin
            check("cyc_wait", 64'(bus.wbm_cyc_o), 64'(1));
            for (int i = 1; i < ack_dly; i++) @(negedge clk);
            bus.wbm_ack_i = 1'b1;
            bus.wbm_dat_i = rdata;
            @(negedge clk);
            bus.wbm_ack_i = 1'b0;
            bus.wbm_dat_i = 32'hFFFF_FFFF;
            check("cyc_after_ack", 64'(bus.wbm_cyc_o), 64'(0));
            check("tx_valid_after_ack", 64'(bus.tx_valid_o), 64'(1));
        end else begin
            k = 0;
            while (bus.wbm_cyc_o && k < 50) begin
                k++;
                @(negedge clk);
            end
            check("timeout_cycles", 64'(k), 64'(TIMEOUT));
        end
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || bus.tx_valid_o) && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("tx_drained", 64'(k < 300), 64'(1));
    endtask

    initial begin
        int k;
        logic [7:0] held;
        rst             = 1'b1;
        bus.rx_valid_i  = 1'b0;
        bus.rx_data_i   = 8'h00;
        bus.tx_ready_i  = 1'b1;
        bus.wbm_dat_i   = 32'h0;
        bus.wbm_stall_i = 1'b0;
        bus.wbm_ack_i   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", 64'({bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.tx_valid_o, overrun}), 64'(0));
        check("rst_buses", 64'({bus.wbm_sel_o, bus.wbm_adr_o, bus.tx_data_o}), 64'(0));
        check("rst_dat", 64'(bus.wbm_dat_o), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Write, ack two cycles after accept
        exp_q.push_back(8'h00);
        fork
            send_frame(8'h8F, 8'h10, 32'hDEADBEEF);
            bus_xact(0, 2, 32'h0, 8'h10, 4'hF, 1'b1, 32'hDEADBEEF);
        join
        wait_drain();

        // Read with three stalled cycles
        push5(8'h00, 32'h12345678);
        fork
            send_frame(8'h03, 8'h20, 32'h0);
            bus_xact(3, 1, 32'h12345678, 8'h20, 4'h3, 1'b0, 32'h0);
        join
        wait_drain();

        // Timeout on a read
        push5(8'hEE, 32'h0);
        fork
            send_frame(8'h0F, 8'h30, 32'h0);
            bus_xact(0, -1, 32'h0, 8'h30, 4'hF, 1'b0, 32'h0);
        join
        wait_drain();

        // Reserved bits ignored, sel=0, ack in the accept cycle
        push5(8'h00, 32'hCAFEF00D);
        fork
            send_frame(8'h70, 8'h7F, 32'h0);
            bus_xact(0, 0, 32'hCAFEF00D, 8'h7F, 4'h0, 1'b0, 32'h0);
        join
        wait_drain();
        check("no_overrun_yet", 64'(overrun), 64'(0));

        // Overrun during WAIT plus tx backpressure
        push5(8'h00, 32'hA1B2C3D4);
        @(posedge clk); #1;
        bus.tx_ready_i = 1'b0;
        fork
            send_frame(8'h01, 8'h40, 32'h0);
            bus_xact(0, 4, 32'hA1B2C3D4, 8'h40, 4'h1, 1'b0, 32'h0);
            begin
                wait_req(k);
                k = 0;
                while (!(bus.wbm_cyc_o && !bus.wbm_stb_o) && k < 100) begin
                    @(negedge clk);
                    k++;
                end
                send(8'h55);
            end
        join
        check("overrun_set", 64'(overrun), 64'(1));
        held = bus.tx_data_o;
        check("bp_status", 64'(held), 64'(8'h00));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 64'(bus.tx_valid_o), 64'(1));
            check("bp_stable", 64'(bus.tx_data_o), 64'(held));
        end
        @(posedge clk); #1;
        bus.tx_ready_i = 1'b1;
        wait_drain();

        // Next frame parses normally (the dropped 0x55 was not taken as CMD)
        exp_q.push_back(8'h00);
        fork
            send_frame(8'h81, 8'h41, 32'h01020304);
            bus_xact(0, 1, 32'h0, 8'h41, 4'h1, 1'b1, 32'h01020304);
        join
        wait_drain();
        check("overrun_sticky", 64'(overrun), 64'(1));

        // Reset while in WAIT
        fork
            send_frame(8'h02, 8'h50, 32'h0);
            begin
                wait_req(k);
                bus.wbm_stall_i = 1'b0;
                @(negedge clk);
                check("in_wait", 64'(bus.wbm_cyc_o && !bus.wbm_stb_o), 64'(1));
                rst = 1'b1;
                @(negedge clk);
                check("rst_wait_cyc", 64'(bus.wbm_cyc_o), 64'(0));
                check("rst_wait_stb", 64'(bus.wbm_stb_o), 64'(0));
                check("rst_wait_tx", 64'(bus.tx_valid_o), 64'(0));
                check("rst_overrun", 64'(overrun), 64'(0));
                rst = 1'b0;
            end
        join
        exp_q.push_back(8'h00);
        fork
            send_frame(8'h8C, 8'h42, 32'h11223344);
            bus_xact(0, 0, 32'h0, 8'h42, 4'hC, 1'b1, 32'h11223344);
        join
        wait_drain();

        // Reset after three bytes of a write frame
        send(8'h8F);
        send(8'h11);
        send(8'hAA);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_partial_cyc", 64'(bus.wbm_cyc_o), 64'(0));
        push5(8'h00, 32'h0BADCAFE);
        fork
            send_frame(8'h05, 8'h60, 32'h0);
            bus_xact(0, 1, 32'h0BADCAFE, 8'h60, 4'h5, 1'b0, 32'h0);
        join
        wait_drain();
        check("overrun_clear", 64'(overrun), 64'(0));
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
